axis_mash11_decim: RTL and testbench

- Receive-side counterpart of the MASH 1-1 DAC modulator.
- Takes the signed DAC_BW-bit MASH code stream over AXI-Stream and reconstructs WIDTH-bit unsigned samples.
- Reconstruction uses an N-stage CIC decimator (rate DECIM) followed by gain normalisation and saturation.
- Used in loopback verification and on ADC-side delta-sigma capture paths.

---
 rtl/axis_mash_pkg.sv | 31 +++
 rtl/axis_mash_cic_int.sv | 19 +
 rtl/axis_mash11_decim.sv | 163 ++++++++++++++++
 tb/tb_axis_mash11_decim.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mash_pkg.sv
// Shared definitions for the MASH 1-1 receive-side decimator.
// Holds the width/shift derivations, the comb sequencer states and the
// legal MASH 1-1 code range.
package axis_mash_pkg;

  // A MASH 1-1 code stream only ever carries -1, 0, 1 or 2
  localparam int MASH_MIN = -1;
  localparam int MASH_MAX = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMB,
    ST_NORM,
    ST_HOLD
  } comb_state_e;

  function automatic int log2c(input int v);
    return $clog2(v);
  endfunction

  // Integrator width: input width plus the CIC bit growth N*log2(R)
  function automatic int cic_bi(input int dac_bw, input int n_stages, input int decim);
    return dac_bw + n_stages * log2c(decim);
  endfunction

  // Right-shift that maps the CIC gain R^N onto the output word width
  function automatic int cic_shift(input int n_stages, input int decim, input int width);
    return n_stages * log2c(decim) - width;
  endfunction

endpackage

// File: rtl/axis_mash_cic_int.sv
// One CIC integrator stage: accumulates din on every enabled cycle.
// The accumulator wraps modulo 2^BI on purpose; the combs cancel the wrap.
module axis_mash_cic_int #(
  parameter int BI = 21
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic                 en,
  input  logic signed [BI-1:0] din,
  output logic signed [BI-1:0] q
);

  // Wrapping accumulator, advanced only on accepted input beats
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) q <= '0;
    else if (en) q <= q + din;
  end

endmodule

// File: rtl/axis_mash11_decim.sv
// MASH 1-1 code stream -> WIDTH-bit unsigned samples.
// N_STAGES wrapping integrators run at the input rate; one time-multiplexed
// comb evaluates one stage per cycle after each decimation strobe, then the
// result is scaled, saturated and held on the output stream.
// Optional build macro DECIM_ROUND_EN: round half up before the scale shift
// instead of truncating.
module axis_mash11_decim
  import axis_mash_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DAC_BW   = 3,
  parameter int DECIM    = 64,
  parameter int N_STAGES = 3
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  logic signed [DAC_BW-1:0] s_axis_data_tdata,
  input  logic                     s_axis_data_tvalid,
  output logic                     s_axis_data_tready,
  output logic [WIDTH-1:0]         m_axis_data_tdata,
  output logic                     m_axis_data_tuser,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready
);

  localparam int LD = log2c(DECIM);
  localparam int BI = cic_bi(DAC_BW, N_STAGES, DECIM);
  localparam int S  = cic_shift(N_STAGES, DECIM, WIDTH);
  localparam int SR = (S >= 0) ? S : 0;
  localparam int SL = (S < 0) ? -S : 0;
  localparam int EW = BI + WIDTH + 2;
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [LD-1:0] LAST = LD'(DECIM - 1);
`ifdef DECIM_ROUND_EN
  localparam int RS = (S > 0) ? S - 1 : 0;
  localparam logic signed [EW-1:0] HALF = EW'(1) <<< RS;
`endif

  // Sign-extend, optionally round, then shift the comb result to WIDTH scale
  function automatic logic signed [EW-1:0] scale(input logic signed [BI-1:0] v);
    logic signed [EW-1:0] x;
    x = {{(EW-BI){v[BI-1]}}, v};
    if (S >= 0) begin
`ifdef DECIM_ROUND_EN
      if (S > 0) x = x + HALF;
`endif
      x = x >>> SR;
    end else begin
      x = x <<< SL;
    end
    return x;
  endfunction

  // Clip to [0, 2^WIDTH-1]; MSB of the result flags a clipped sample
  function automatic logic [WIDTH:0] saturate(input logic signed [EW-1:0] x);
    if (x[EW-1]) return {1'b1, {WIDTH{1'b0}}};
    if (|x[EW-2:WIDTH]) return {1'b1, {WIDTH{1'b1}}};
    return {1'b0, x[WIDTH-1:0]};
  endfunction

  comb_state_e           state;
  logic                  rdy_p0;
  logic [LD-1:0]         phase_p0;
  logic                  busy;
  logic                  beat;
  logic                  strobe;
  logic [SW-1:0]         stg_p1;
  logic signed [BI-1:0]  comb_p1;
  logic signed [BI-1:0]  dly_p1 [N_STAGES];
  logic [WIDTH-1:0]      dout_p2;
  logic                  user_p2;
  logic                  vld_p2;
  logic signed [BI-1:0]  int_din [N_STAGES];
  logic signed [BI-1:0]  int_q   [N_STAGES];

  // A pending output only blocks the beat that would raise the next strobe;
  // a HOLD that is being drained this cycle counts as free.
  assign busy   = (state != ST_IDLE) && !((state == ST_HOLD) && m_axis_data_tready);
  assign s_axis_data_tready = rdy_p0 && !((phase_p0 == LAST) && busy);
  assign beat   = s_axis_data_tvalid && s_axis_data_tready;
  assign strobe = beat && (phase_p0 == LAST);

  // ---- stage p0: integrator chain at input rate ----
  assign int_din[0] = {{(BI-DAC_BW){s_axis_data_tdata[DAC_BW-1]}}, s_axis_data_tdata};

  for (genvar k = 0; k < N_STAGES; k++) begin : g_int
    if (k > 0) begin : g_chain
      assign int_din[k] = int_q[k-1];
    end
    axis_mash_cic_int #(.BI(BI)) u_int (
      .aclk (aclk),
      .arst (arst),
      .en   (beat),
      .din  (int_din[k]),
      .q    (int_q[k])
    );
  end

  // Input ready comes up on the first clock after reset release
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) rdy_p0 <= 1'b0;
    else rdy_p0 <= 1'b1;
  end

  // Decimation phase, one step per accepted beat
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) phase_p0 <= '0;
    else if (beat) phase_p0 <= phase_p0 + LD'(1);
  end

  // ---- stage p1: serial comb, stage p2: normalised output hold ----
  // Comb sequencer: latch, N comb cycles, normalise, hold until taken
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state   <= ST_IDLE;
      stg_p1  <= '0;
      comb_p1 <= '0;
      for (int k = 0; k < N_STAGES; k++) dly_p1[k] <= '0;
      dout_p2 <= '0;
      user_p2 <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            comb_p1 <= int_q[N_STAGES-1];
            stg_p1  <= '0;
            state   <= ST_COMB;
          end
        end
        ST_COMB: begin
          comb_p1        <= comb_p1 - dly_p1[stg_p1];
          dly_p1[stg_p1] <= comb_p1;
          if (stg_p1 == SW'(N_STAGES - 1)) state <= ST_NORM;
          else stg_p1 <= stg_p1 + SW'(1);
        end
        ST_NORM: begin
          {user_p2, dout_p2} <= saturate(scale(comb_p1));
          vld_p2 <= 1'b1;
          state  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (m_axis_data_tready) begin
            vld_p2 <= 1'b0;
            if (strobe) begin
              comb_p1 <= int_q[N_STAGES-1];
              stg_p1  <= '0;
              state   <= ST_COMB;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_data_tdata  = dout_p2;
  assign m_axis_data_tuser  = user_p2;
  assign m_axis_data_tvalid = vld_p2;

endmodule

// File: tb/tb_axis_mash11_decim.sv
// Bench for axis_mash11_decim: random and directed code streams checked
// against an unbounded-integer CIC reference model and a MASH 1-1 source.
module tb_axis_mash11_decim;
  import axis_mash_pkg::*;

  localparam int WIDTH    = 16;
  localparam int DAC_BW   = 3;
  localparam int DECIM    = 64;
  localparam int N_STAGES = 3;
  localparam int SH       = N_STAGES * $clog2(DECIM) - WIDTH;
  localparam longint DIV  = longint'(1) << SH;
  localparam longint MAXV = (longint'(1) << WIDTH) - 1;

  logic aclk = 1'b0;
  logic arst = 1'b1;
  logic signed [DAC_BW-1:0] s_tdata = '0;
  logic s_tvalid = 1'b0;
  logic s_tready;
  logic [WIDTH-1:0] m_tdata;
  logic m_tuser;
  logic m_tvalid;
  logic m_tready = 1'b1;

  axis_mash11_decim #(
    .WIDTH(WIDTH), .DAC_BW(DAC_BW), .DECIM(DECIM), .N_STAGES(N_STAGES)
  ) dut (
    .aclk               (aclk),
    .arst               (arst),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tuser  (m_tuser),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready)
  );

  initial forever #5 aclk = ~aclk;

  int ncmp = 0;
  int nfail = 0;
  int stall_cnt = 0;
  int mrdy_mode = 0;
  int hold_cnt = 0;

  longint integ [N_STAGES];
  longint cdly  [N_STAGES];
  int m_phase = 0;
  int pending = 0;
  int cyc = 0;
  logic rdy_m;
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  logic [WIDTH:0] prev_o = '0;
  logic [WIDTH:0] exp_q [$];
  logic [WIDTH:0] got_q [$];
  int strobe_q [$];

  // Reference scale: floor division by 2^SH (optionally round half up), then clip
  function automatic logic [WIDTH:0] ref_norm(input longint v);
    longint w, q;
    w = v;
`ifdef DECIM_ROUND_EN
    if (SH > 0) w = w + DIV / 2;
`endif
    if (w >= 0) q = w / DIV;
    else q = -((-w + DIV - 1) / DIV);
    if (q < 0) return {1'b1, {WIDTH{1'b0}}};
    if (q > MAXV) return {1'b1, {WIDTH{1'b1}}};
    return {1'b0, q[WIDTH-1:0]};
  endfunction

  always @(posedge aclk or posedge arst) begin
    if (arst) rdy_m <= 1'b0;
    else rdy_m <= 1'b1;
  end

  // m_tready driver: held low while hold_cnt runs, else always-on or random
  initial forever begin
    @(posedge aclk);
    #1;
    if (hold_cnt > 0) begin
      m_tready = 1'b0;
      hold_cnt--;
    end else if (mrdy_mode == 1) begin
      m_tready = ($urandom_range(0, 3) != 0);
    end else begin
      m_tready = 1'b1;
    end
  end

  // Reference model and scoreboard, sampled mid-cycle
  always @(negedge aclk) begin
    logic exp_rdy;
    logic [WIDTH:0] cur, e;
    longint v, t;
    int x, ts;
    if (arst) begin
      for (int k = 0; k < N_STAGES; k++) begin integ[k] = 0; cdly[k] = 0; end
      m_phase = 0; pending = 0;
      exp_q.delete(); strobe_q.delete();
      prev_v = 1'b0; prev_r = 1'b0; prev_o = '0;
    end else begin
      cur = {m_tuser, m_tdata};
      exp_rdy = rdy_m && !(m_phase == DECIM - 1 && pending > 0 && !m_tready);
      ncmp++;
      if (s_tready !== exp_rdy) begin
        nfail++;
        $display("FAIL s_tready cyc=%0d phase=%0d got=%b exp=%b", cyc, m_phase, s_tready, exp_rdy);
      end
      if (!s_tready) stall_cnt++;
      if (prev_v && !prev_r) begin
        ncmp++;
        if (m_tvalid !== 1'b1 || cur !== prev_o) begin
          nfail++;
          $display("FAIL hold_stable cyc=%0d got v=%b %h exp v=1 %h", cyc, m_tvalid, cur, prev_o);
        end
      end
      if (m_tvalid && !prev_v) begin
        ncmp++;
        if (strobe_q.size() == 0) begin
          nfail++;
          $display("FAIL tvalid_spurious cyc=%0d got tvalid=1 exp tvalid=0", cyc);
        end else begin
          ts = strobe_q.pop_front();
          // strobe beat sampled in cycle ts; its edge plus N_STAGES+1 edges later tvalid is up
          if (cyc - ts != N_STAGES + 2) begin
            nfail++;
            $display("FAIL latency got=%0d exp=%0d", cyc - ts, N_STAGES + 2);
          end
        end
      end
      if (m_tvalid && m_tready) begin
        ncmp++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL output_unexpected cyc=%0d got=%h exp=none", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          pending--;
          if (cur !== e) begin
            nfail++;
            $display("FAIL output cyc=%0d got user=%b data=%h exp user=%b data=%h",
                     cyc, cur[WIDTH], cur[WIDTH-1:0], e[WIDTH], e[WIDTH-1:0]);
          end
        end
        got_q.push_back(cur);
      end
      if (s_tvalid && s_tready) begin
        x = int'(s_tdata);
        if (m_phase == DECIM - 1) begin
          v = integ[N_STAGES-1];
          for (int k = 0; k < N_STAGES; k++) begin
            t = v - cdly[k];
            cdly[k] = v;
            v = t;
          end
          exp_q.push_back(ref_norm(v));
          pending++;
          strobe_q.push_back(cyc);
        end
        for (int k = N_STAGES - 1; k > 0; k--) integ[k] = integ[k] + integ[k-1];
        integ[0] = integ[0] + longint'(x);
        m_phase = (m_phase + 1) % DECIM;
      end
      prev_v = m_tvalid; prev_r = m_tready; prev_o = cur;
      cyc++;
    end
  end

  task automatic do_reset();
    @(posedge aclk); #1;
    arst = 1'b1; s_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1; arst = 1'b0;
    @(posedge aclk); #1;
    got_q.delete();
    stall_cnt = 0;
  endtask

  task automatic send(input int code, input bit gaps);
    int guard;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      @(posedge aclk); #1;
    end
    s_tdata = DAC_BW'(code);
    s_tvalid = 1'b1;
    guard = 0;
    forever begin
      @(negedge aclk);
      if (s_tready) break;
      guard++;
      if (guard > 2000) begin
        ncmp++; nfail++;
        $display("FAIL send_timeout got stalled=%0d cycles exp <=2000", guard);
        break;
      end
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
  endtask

  // mode 0 constant, 1 alternating 0/1, 2 random legal code, 3 MASH 1-1 of cval
  task automatic stream(input int n, input int mode, input int cval, input bit gaps);
    int unsigned a1, a2, s1, s2;
    int c1, c2, c2d, code;
    a1 = 0; a2 = 0; c2d = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: code = cval;
        1: code = i % 2;
        2: code = int'($urandom_range(0, MASH_MAX - MASH_MIN)) + MASH_MIN;
        default: begin
          s1 = a1 + cval;  c1 = int'(s1 >> 16); a1 = s1 & 32'hFFFF;
          s2 = a2 + a1;    c2 = int'(s2 >> 16); a2 = s2 & 32'hFFFF;
          code = c1 + c2 - c2d;
          c2d = c2;
        end
      endcase
      send(code, gaps);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || m_tvalid) && guard < 3000) begin
      @(negedge aclk);
      guard++;
    end
    ncmp++;
    if (exp_q.size() != 0 || m_tvalid) begin
      nfail++;
      $display("FAIL drain_timeout got pending=%0d exp=0", exp_q.size());
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    @(posedge aclk); #1;
    arst = 1'b1; #1;
    ncmp++; if (s_tready !== 1'b0) begin nfail++; $display("FAIL rst_tready got=%b exp=0", s_tready); end
    ncmp++; if (m_tvalid !== 1'b0) begin nfail++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    ncmp++; if (m_tdata !== '0) begin nfail++; $display("FAIL rst_tdata got=%h exp=0", m_tdata); end
    ncmp++; if (m_tuser !== 1'b0) begin nfail++; $display("FAIL rst_tuser got=%b exp=0", m_tuser); end
    repeat (2) @(posedge aclk);
    #1; arst = 1'b0;
    @(posedge aclk); #1;
    ncmp++; if (s_tready !== 1'b1) begin nfail++; $display("FAIL rel_tready got=%b exp=1", s_tready); end
    ncmp++; if (m_tvalid !== 1'b0) begin nfail++; $display("FAIL rel_tvalid got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_const_zero();
    do_reset();
    mrdy_mode = 0;
    stream(6 * DECIM, 0, 0, 1'b0);
    drain();
    ncmp++; if (got_q.size() != 6) begin nfail++; $display("FAIL zero_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      ncmp++;
      if (got_q[i] !== '0) begin nfail++; $display("FAIL zero_val idx=%0d got=%h exp=0", i, got_q[i]); end
    end
  endtask

  task automatic test_alternating();
    do_reset();
    mrdy_mode = 0;
    stream(8 * DECIM, 1, 0, 1'b0);
    drain();
    ncmp++; if (got_q.size() != 8) begin nfail++; $display("FAIL alt_count got=%0d exp=8", got_q.size()); end
    for (int i = 3; i < got_q.size(); i++) begin
      ncmp++;
      if (got_q[i] !== {1'b0, 16'h8000}) begin
        nfail++; $display("FAIL alt_val idx=%0d got=%h exp=08000", i, got_q[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [WIDTH:0] want;
    int code;
    for (int c = 0; c < 2; c++) begin
      code = (c == 0) ? MASH_MAX : MASH_MIN;
      want = (c == 0) ? {1'b1, 16'hFFFF} : {1'b1, 16'h0000};
      do_reset();
      mrdy_mode = 0;
      stream(6 * DECIM, 0, code, 1'b0);
      drain();
      ncmp++; if (got_q.size() != 6) begin nfail++; $display("FAIL sat_count code=%0d got=%0d exp=6", code, got_q.size()); end
      for (int i = 3; i < got_q.size(); i++) begin
        ncmp++;
        if (got_q[i] !== want) begin
          nfail++; $display("FAIL sat_val code=%0d idx=%0d got=%h exp=%h", code, i, got_q[i], want);
        end
      end
    end
  endtask

  task automatic test_loopback();
    int d;
    do_reset();
    mrdy_mode = 0;
    stream(10 * DECIM, 3, 32'h4000, 1'b1);
    drain();
    ncmp++; if (got_q.size() != 10) begin nfail++; $display("FAIL loop_count got=%0d exp=10", got_q.size()); end
    for (int i = 3; i < got_q.size(); i++) begin
      d = int'(got_q[i][WIDTH-1:0]) - 32'h4000;
      ncmp++;
      if (got_q[i][WIDTH] !== 1'b0 || d > 2 || d < -2) begin
        nfail++; $display("FAIL loop_val idx=%0d got=%h exp=4000+-2", i, got_q[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    mrdy_mode = 1;
    stream(12 * DECIM, 2, 0, 1'b1);
    mrdy_mode = 0;
    drain();
    ncmp++; if (got_q.size() != 12) begin nfail++; $display("FAIL rand_count got=%0d exp=12", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mrdy_mode = 0;
    hold_cnt = 200;
    stream(8 * DECIM, 2, 0, 1'b0);
    drain();
    ncmp++; if (got_q.size() != 8) begin nfail++; $display("FAIL bp_count got=%0d exp=8", got_q.size()); end
    ncmp++; if (stall_cnt == 0) begin nfail++; $display("FAIL bp_stall got=0 stall cycles exp>0"); end
  endtask

  task automatic test_reset_mid_comb();
    do_reset();
    mrdy_mode = 0;
    stream(5 * DECIM, 1, 0, 1'b0);
    // the last beat was the strobe; the sequencer is now combing
    #2; arst = 1'b1; #1;
    ncmp++; if (m_tvalid !== 1'b0) begin nfail++; $display("FAIL mid_tvalid got=%b exp=0", m_tvalid); end
    ncmp++; if (m_tdata !== '0) begin nfail++; $display("FAIL mid_tdata got=%h exp=0", m_tdata); end
    ncmp++; if (m_tuser !== 1'b0) begin nfail++; $display("FAIL mid_tuser got=%b exp=0", m_tuser); end
    ncmp++; if (s_tready !== 1'b0) begin nfail++; $display("FAIL mid_tready got=%b exp=0", s_tready); end
    repeat (2) @(posedge aclk);
    #1; arst = 1'b0;
    @(posedge aclk); #1;
    got_q.delete();
    stream(8 * DECIM, 1, 0, 1'b0);
    drain();
    ncmp++; if (got_q.size() != 8) begin nfail++; $display("FAIL mid_count got=%0d exp=8", got_q.size()); end
    for (int i = 3; i < got_q.size(); i++) begin
      ncmp++;
      if (got_q[i] !== {1'b0, 16'h8000}) begin
        nfail++; $display("FAIL mid_val idx=%0d got=%h exp=08000", i, got_q[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_const_zero();
    test_alternating();
    test_saturation();
    test_loopback();
    test_random();
    test_back_to_back();
    test_reset_mid_comb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
